// File: rtl/psc_trigger.sv
`timescale 1ns/1ps
// psc_trigger: turns an async active-low EVR trigger into one UART-style frame (start, TRIG_CODE LSB first, stop).
// Define PSC_TRIG_PARITY_EN to insert an even-parity bit before the stop bit.
module psc_trigger #(
  parameter int unsigned CLKS_PER_BIT = 50,
  parameter logic [7:0]  TRIG_CODE    = 8'h20
) (
  input  logic clk,
  input  logic reset,
  input  logic evr_trigger,
  output logic psc_output
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PSC_TRIG_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
`ifdef PSC_TRIG_PARITY_EN
  localparam logic PARITY_BIT = ^TRIG_CODE;
`endif

  logic        sync1, sync2, hist, edge_q, armed;
  logic [1:0]  vld_pipe;
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic        bit_end;

  assign bit_end = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      hist       <= 1'b1;
      vld_pipe   <= '0;
      armed      <= 1'b0;
      edge_q     <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      psc_output <= 1'b1;
    end else begin
      sync1    <= evr_trigger;
      sync2    <= sync1;
      hist     <= sync2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      // Only arm once a real high has been synchronized, so a line held low through reset never fires.
      armed    <= armed | (vld_pipe[1] & sync2);
      edge_q   <= armed & hist & ~sync2;
      cnt      <= bit_end ? '0 : cnt + 16'd1;

      case (state)
        IDLE: begin
          cnt        <= '0;
          bit_idx    <= '0;
          psc_output <= 1'b1;
          if (edge_q) begin
            state      <= START;
            psc_output <= 1'b0;
          end
        end
        START: if (bit_end) begin
          state      <= DATA;
          psc_output <= TRIG_CODE[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef PSC_TRIG_PARITY_EN
            state      <= PARITY;
            psc_output <= PARITY_BIT;
`else
            state      <= STOP;
            psc_output <= 1'b1;
`endif
          end else begin
            bit_idx    <= bit_idx + 3'd1;
            psc_output <= TRIG_CODE[bit_idx + 3'd1];
          end
        end
`ifdef PSC_TRIG_PARITY_EN
        PARITY: if (bit_end) begin
          state      <= STOP;
          psc_output <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state      <= IDLE;
          psc_output <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          psc_output <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psc_trigger.sv
`timescale 1ns/1ps
// tb_psc_trigger: per-cycle reference model of the trigger frame plus directed, table and random stimulus.
module tb_psc_trigger;
  localparam int CPB = 50;
  localparam logic [7:0] CODE = 8'h20;
`ifdef PSC_TRIG_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = NB * CPB;

  typedef struct {
    int len1;
    int gap;
    int len2;
    int exp_frames;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic evr_trigger = 1'b1;
  logic psc_output;

  psc_trigger #(.CLKS_PER_BIT(CPB), .TRIG_CODE(CODE)) dut (
    .clk(clk),
    .reset(reset),
    .evr_trigger(evr_trigger),
    .psc_output(psc_output)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   frames = 0;
  int   low_cycles = 0;
  logic fbits [NB];
  logic s_rst, s_evr;

  always @(posedge clk) begin
    s_rst <= reset;
    s_evr <= evr_trigger;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    evr_trigger = 1'b0;
    cycles(n);
    evr_trigger = 1'b1;
  endtask

  // Reference: a falling sample (after a real high) schedules a frame start 3 edges later,
  // accepted only if the previous frame has finished and the line sat idle for an edge.
  initial begin : model
    int   cyc;
    bit   prev;
    int   q[$];
    bit   active;
    int   fstart;
    int   high_run;
    logic exp;
    logic last_out;
    logic [7:0] code;
    cyc = 0; prev = 0; active = 0; fstart = 0; high_run = 1000; last_out = 1'b1;
    code = CODE;
    fbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[i+1] = code[i];
`ifdef PSC_TRIG_PARITY_EN
    fbits[9] = ^code;
`endif
    fbits[NB-1] = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (s_rst) begin
        prev = 0;
        q.delete();
        active = 0;
      end else begin
        if (prev && !s_evr) q.push_back(cyc + 3);
        prev = s_evr;
        if (q.size() > 0 && q[0] == cyc) begin
          void'(q.pop_front());
          if (!active || cyc >= fstart + L + 1) begin
            active = 1;
            fstart = cyc;
          end
        end
      end
      exp = (active && (cyc - fstart) < L) ? fbits[(cyc - fstart) / CPB] : 1'b1;
      check_bit("psc_output vs model", psc_output, exp);
      if (!psc_output) low_cycles++;
      if (last_out && !psc_output && high_run > CPB) frames++;
      high_run = psc_output ? high_run + 1 : 0;
      last_out = psc_output;
    end
  end

  initial begin : stim
    vec_t vt [7];
    int   f0;
    vt[0] = '{3, 0, 0, 1};
    vt[1] = '{2, 0, 0, 1};
    vt[2] = '{700, 0, 0, 1};
    vt[3] = '{3, 200, 3, 1};
    vt[4] = '{3, L, 3, 1};
    vt[5] = '{3, L + 1, 3, 2};
    vt[6] = '{3, L + 100, 3, 2};

    reset = 1'b1;
    evr_trigger = 1'b1;
    cycles(5);
    check_bit("reset output", psc_output, 1'b1);
    reset = 1'b0;

    #(10000 - $time);
    check_int("idle low cycles", low_cycles, 0);
    check_bit("idle output", psc_output, 1'b1);

    // Single trigger with absolute timing (first sampling edge at 15005 ns)
    f0 = frames;
    #(15000 - $time);
    evr_trigger = 1'b0;
    #(15030 - $time);
    check_bit("before start bit", psc_output, 1'b1);
    #(15040 - $time);
    check_bit("start bit edge", psc_output, 1'b0);
    for (int i = 0; i < NB - 1; i++) begin
      #(15290 + 500 * i - $time);
      check_bit($sformatf("frame bit %0d", i), psc_output, fbits[i]);
    end
    #(15040 + 500 * (NB - 1) - $time);
    check_bit("stop bit begins", psc_output, 1'b1);
    #(21000 - $time);
    evr_trigger = 1'b1;
    #(25000 - $time);
    check_int("single trigger frames", frames - f0, 1);

    // Reset in the middle of data bit 2
    f0 = frames;
    pulse(3);
    cycles(170);
    reset = 1'b1;
    cycles(1);
    check_bit("reset aborts frame", psc_output, 1'b1);
    cycles(1);
    reset = 1'b0;
    cycles(600);
    check_int("aborted frame only", frames - f0, 1);
    pulse(3);
    cycles(700);
    check_int("frame after reset", frames - f0, 2);

    // Trigger falls during reset and stays low afterwards
    f0 = frames;
    reset = 1'b1;
    cycles(2);
    evr_trigger = 1'b0;
    cycles(5);
    reset = 1'b0;
    cycles(700);
    check_int("no frame with trigger low across reset", frames - f0, 0);
    evr_trigger = 1'b1;
    cycles(10);

    foreach (vt[i]) begin
      f0 = frames;
      pulse(vt[i].len1);
      if (vt[i].gap > 0) begin
        cycles(vt[i].gap - vt[i].len1);
        pulse(vt[i].len2);
      end
      cycles(1200);
      check_int($sformatf("table vector %0d frames", i), frames - f0, vt[i].exp_frames);
    end

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        cycles(int'($urandom_range(1, 4)));
        reset = 1'b0;
      end
      evr_trigger = 1'b0;
      cycles(($urandom_range(0, 5) == 0) ? int'($urandom_range(100, 600)) : int'($urandom_range(1, 6)));
      evr_trigger = 1'b1;
      cycles(int'($urandom_range(1, 700)));
    end
    cycles(700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
